// File: rtl/sign_reapply.sv
// Sign bookkeeping around a magnitude-only stage. The forward side strips the
// sign and queues it; the return side pops the oldest sign and re-applies it
// to the processed magnitude with saturation to the signed output range.
module sign_reapply #(
   parameter int WIDTH  = 16,
   parameter int OWIDTH = 16,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic [WIDTH-1:0]  in,
   output logic              in_rdy,
   output logic              mag_vld,
   output logic [WIDTH-1:0]  mag_out,
   input  logic              ret_vld,
   input  logic [OWIDTH-1:0] ret_mag,
   output logic              out_vld,
   output logic [OWIDTH-1:0] out,
   output logic              sat,
   output logic [AW:0]       count,
   output logic              ovf,
   output logic              unf
);

   localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [OWIDTH-1:0] POS_MAX  = {1'b0, {(OWIDTH-1){1'b1}}};
   localparam logic [OWIDTH-1:0] NEG_MAG  = {1'b1, {(OWIDTH-1){1'b0}}};

   logic [DEPTH-1:0]  sign_mem_q, sign_mem_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              mag_vld_q, mag_vld_d;
   logic [WIDTH-1:0]  mag_q, mag_d;
   logic              out_vld_q, out_vld_d;
   logic [OWIDTH-1:0] out_q, out_d;
   logic              sat_q, sat_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              accept;
   logic              pop;
   logic              sign_s;
   logic [WIDTH-1:0]  neg_in;

   // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
   assign in_rdy = (count_q != FULL_CNT) && !rst;
   assign accept = in_vld && in_rdy;
   assign pop    = ret_vld && (count_q != '0);
   assign sign_s = pop ? sign_mem_q[rd_ptr_q] : 1'b0;
   assign neg_in = ~in + WIDTH'(1);

   // Next-state: FIFO bookkeeping, magnitude extraction and sign re-application.
   always_comb begin
      // NOTE: every _d gets a default first so no path through the block can infer a latch.
      sign_mem_d = sign_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mag_vld_d  = accept;
      mag_d      = '0;
      out_vld_d  = ret_vld;
      out_d      = '0;
      sat_d      = 1'b0;
      ovf_d      = ovf_q | (in_vld && !in_rdy);
      unf_d      = unf_q | (ret_vld && (count_q == '0));
      count_d    = count_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

      if (accept) begin
         sign_mem_d[wr_ptr_q] = in[WIDTH-1];
         wr_ptr_d             = wr_ptr_q + AW'(1);
         mag_d                = in[WIDTH-1] ? neg_in : in;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (ret_vld) begin
         if (!sign_s) begin
            if (ret_mag > POS_MAX) begin
               out_d = POS_MAX;
               sat_d = 1'b1;
            end else begin
               out_d = ret_mag;
            end
         end else begin
            if (ret_mag > NEG_MAG) begin
               out_d = NEG_MAG;
               sat_d = 1'b1;
            end else begin
               out_d = ~ret_mag + OWIDTH'(1);
            end
         end
      end
   end

   // Sign storage: contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      // NOTE: the sign array is left out of reset; reset empties it by clearing the pointers and count.
      sign_mem_q <= sign_mem_d;
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         mag_vld_q <= 1'b0;
         mag_q     <= '0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
         sat_q     <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         mag_vld_q <= mag_vld_d;
         mag_q     <= mag_d;
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
         sat_q     <= sat_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign mag_vld = mag_vld_q;
   assign mag_out = mag_q;
   assign out_vld = out_vld_q;
   assign out     = out_q;
   assign sat     = sat_q;
   assign count   = count_q;
   assign ovf     = ovf_q;
   assign unf     = unf_q;

endmodule

// File: doc/sign_reapply.md
Name: sign_reapply

Overview:
- Two-sided sign bookkeeping block for the PSK receive datapath.
- Forward side: takes a signed sample and emits its unsigned magnitude. The sign bit is stored in an internal FIFO.
- Return side: when the processed magnitude comes back from a downstream variable-latency stage (scaler, divider, AGC), the oldest stored sign is popped and re-applied, producing a saturated signed result.
- Lets magnitude-only processing sit between the two sides without losing polarity.

Parameters:
- WIDTH, 16, forward sample width (two's complement in, unsigned magnitude out).
- OWIDTH, 16, width of the returned magnitude and of the signed output.
- DEPTH, 16, sign FIFO depth. Must be a power of 2 and ≥ 2.
- AW, log2(DEPTH), FIFO pointer width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_vld  in  1  forward sample valid.
- in  in  WIDTH  forward sample, two's complement; bit WIDTH-1 is the sign.
- in_rdy  out  1  forward accept. Equals (count != DEPTH) && !rst.
- mag_vld  out  1  magnitude valid, one cycle after an accepted sample.
- mag_out  out  WIDTH  unsigned magnitude.
- ret_vld  in  1  returned magnitude valid.
- ret_mag  in  OWIDTH  returned unsigned magnitude.
- out_vld  out  1  signed result valid.
- out  out  OWIDTH  signed result.
- sat  out  1  one-cycle pulse, coincident with out_vld, when the result was saturated.
- count  out  AW+1  FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky: a sample was presented while in_rdy=0.
- unf  out  1  sticky: ret_vld arrived while the FIFO was empty.

Behaviour:
- Reset, synchronous: mag_vld, mag_out, out_vld, out, sat, count, ovf, unf all 0. FIFO pointers are 0. in_rdy is 0 while rst is high and 1 on the first cycle after.
- Accept: accept = in_vld && in_rdy.
  - On accept, the next cycle gives mag_vld=1 and mag_out = in[WIDTH-1] ? (~in+1) : in, truncated to WIDTH bits, unsigned.
  - Most negative input 2^(WIDTH-1) yields mag_out = 2^(WIDTH-1). This value is unsigned and correct, not an overflow.
  - On the same clock edge, in[WIDTH-1] is pushed to the FIFO.
  - On cycles without an accept: mag_vld=0 and mag_out=0.
- Reject: in_vld && !in_rdy → sample dropped, no push, mag_vld=0 next cycle, ovf set. ovf and unf clear only on rst.
- Return: on ret_vld, the result is registered with 1 cycle latency.
  - If count>0: pop sign s (FIFO order = accept order).
  - If count==0: unf set, no pop, s treated as 0.
  - Next cycle: out_vld=1.
  - s=0: out = min(ret_mag, 2^(OWIDTH-1)-1).
  - s=1: out = −min(ret_mag, 2^(OWIDTH-1)) in two's complement.
  - sat=1 when clamping occurred.
  - ret_mag=0 with s=1 gives out=0.
  - Without ret_vld: out_vld=0, out=0, sat=0.
- Simultaneous push and pop: both occur and count is unchanged. No bypass: a sign pushed this cycle cannot be popped this cycle. If count==0 this is an underflow, even with a simultaneous accept.
- Full: in_rdy depends on the registered count only. At count==DEPTH a simultaneous pop does not make in_rdy=1 in that cycle.
- Pointers wrap modulo DEPTH. count tracks pushes minus pops exactly.
- Reset mid-operation: all stored signs are discarded and count=0. Returns arriving after reset flag unf.

Test Plan:
- Reset check (WIDTH=OWIDTH=16, DEPTH=4): hold rst 3 cycles → all outputs 0, in_rdy=0 during rst; first cycle after rst → in_rdy=1, count=0.
- Forward and return round trip:
  - Stimulus: accept in=0xFFFB, 0x0007, 0x8000 on consecutive cycles.
  - Forward response: mag_out = 0x0005, 0x0007, 0x8000 with mag_vld one cycle after each; count reaches 3.
  - Stimulus: return ret_mag = 0x000A, 0x000E, 0x8000.
  - Return response: out = 0xFFF6, 0x000E, 0x8000; sat=0 on all; count returns to 0.
- Full and overflow:
  - Stimulus: 4 accepts, then in_vld on the 5th cycle.
  - Response: in_rdy=0, no mag_vld, ovf=1, count=4.
  - Stimulus: at count 4, assert in_vld and ret_vld together.
  - Response: the pop occurs, the push is rejected, count=3.
- Underflow: ret_vld with ret_mag=0x0003 at count=0 → out=0x0003, out_vld=1, unf=1, count stays 0.
- Saturation:
  - Accept 0x0001 then 0xFFFF; return 0x8000 then 0x9000.
  - Response: out=0x7FFF with sat=1, then out=0x8000 with sat=1.
  - Return 0x8000 against a negative sign → out=0x8000, sat=0.
- Reset mid-operation and wrap:
  - Stimulus: count=3, assert rst 1 cycle, then ret_vld.
  - Response: count=0, flags cleared by rst, unf=1 after the return.
  - Stimulus: 10 interleaved push/pop pairs across the pointer wrap.
  - Response: every popped sign matches its accept order.
